// File: rtl/pulse_flasher_pkg.sv
// Shared types and helpers for the pulse_flasher LED event display block.
package pulse_flasher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Tick counter shared by the ON and OFF phases; done fires on the limit-th tick.
module ms_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done = tick && (cnt_q == limit - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (done) cnt_d = '0;
    else if (tick) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pulse_flasher.sv
// Turns 1-clk event pulses into visible LED flashes, queueing events that arrive too fast.
module pulse_flasher
  import pulse_flasher_pkg::*;
#(
  parameter int unsigned ON_MS  = 100,
  parameter int unsigned OFF_MS = 100,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1ms,
  input  logic             pulse_in,
  input  logic             clr_ovf,
  output logic             led_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             ovf
);

  localparam int unsigned MAX_MS = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int unsigned TW     = clog2(MAX_MS + 1);

  state_t           state_q, state_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;

  logic          enter_on, have_evt, ovf_set, tmr_clr, tmr_done;
  logic [TW-1:0] tmr_limit;

  assign tmr_limit = (state_q == ST_OFF) ? TW'(OFF_MS) : TW'(ON_MS);

  ms_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .tick  (tick_1ms),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    enter_on = 1'b0;
    have_evt = pulse_in || (pend_q != '0);
    case (state_q)
      ST_IDLE: if (have_evt) begin
        state_d  = ST_ON;
        enter_on = 1'b1;
      end
      ST_ON: if (tmr_done) state_d = ST_OFF;
      ST_OFF: if (tmr_done) begin
        if (have_evt) begin
          state_d  = ST_ON;
          enter_on = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Clearing on the transition drops any tick seen in that cycle, so it stays with the old state.
    tmr_clr = (state_q == ST_IDLE) || (state_d != state_q);
    led_d   = (state_d == ST_ON);
    busy_d  = (state_d != ST_IDLE);
  end

  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (pulse_in && !enter_on) begin
      if (&pend_q) ovf_set = 1'b1;
      else         pend_d  = pend_q + CNT_W'(1);
    end else if (!pulse_in && enter_on) begin
      pend_d = pend_q - CNT_W'(1);
    end
    ovf_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign led_out = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_pulse_flasher.sv
// Scoreboard bench for pulse_flasher: stimulus queues expected flashes, a monitor checks them.
module tb_pulse_flasher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1ms = 1'b0;
  logic       pulse_in = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       led_out, busy, ovf;
  logic [1:0] pending;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int width;
    int gap;
    int pend;
  } flash_t;
  flash_t exp_q[$];

  pulse_flasher #(.ON_MS(3), .OFF_MS(2), .CNT_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1ms (tick_1ms),
    .pulse_in (pulse_in),
    .clr_ovf  (clr_ovf),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Ticks are sampled at posedges whose cycle number is a multiple of 4.
  initial forever begin
    @(negedge clk);
    tick_1ms = (cyc % 4 == 3);
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_flash(input int w, input int g, input int p);
    flash_t e;
    e.width = w;
    e.gap   = g;
    e.pend  = p;
    exp_q.push_back(e);
  endtask

  // Monitor: a flash is measured from its first high sample to its first low sample.
  initial begin
    bit     in_flash = 1'b0;
    int     rise_c = 0;
    int     last_fall = -1000;
    int     pend_s = 0;
    int     gap_s = 0;
    flash_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_flash = 1'b0;
      end else if (led_out && !in_flash) begin
        in_flash = 1'b1;
        rise_c   = cyc;
        pend_s   = int'(pending);
        gap_s    = cyc - last_fall;
      end else if (!led_out && in_flash) begin
        in_flash  = 1'b0;
        last_fall = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_flash: got flash of width %0d, expected none (cycle %0d)",
                   cyc - rise_c, cyc);
        end else begin
          e = exp_q.pop_front();
          check("flash_width", cyc - rise_c, e.width);
          check("flash_pend_at_start", pend_s, e.pend);
          if (e.gap >= 0) check("flash_gap", gap_s, e.gap);
        end
      end
    end
  end

  task automatic align();
    do @(negedge clk); while (cyc % 4 != 3);
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      @(negedge clk);
    end
    pulse_in = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("idle_reached", int'(busy), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", int'({led_out, busy, pending, ovf}), 0);
    end

    // Single event: 12-cycle flash then 8-cycle dark gap.
    align();
    expect_flash(12, -1, 0);
    pulses(1);
    check("single_latency_led", int'(led_out), 1);
    wait_idle(n);
    check("single_busy_len", n, 20);
    check("single_pending", int'(pending), 0);
    check("single_sb_empty", exp_q.size(), 0);

    // Three back-to-back events.
    align();
    expect_flash(12, -1, 0);
    expect_flash(12, 8, 1);
    expect_flash(12, 8, 0);
    pulse_in = 1'b1;
    @(negedge clk);
    check("burst3_pend_a", int'(pending), 0);
    @(negedge clk);
    check("burst3_pend_b", int'(pending), 1);
    @(negedge clk);
    pulse_in = 1'b0;
    check("burst3_pend_c", int'(pending), 2);
    wait_idle(n);
    check("burst3_busy_len", n, 58);
    check("burst3_sb_empty", exp_q.size(), 0);

    // Saturation: five events during ON overflow a 2-bit counter.
    align();
    t0 = cyc;
    expect_flash(12, -1, 0);
    expect_flash(12, 8, 2);
    expect_flash(12, 8, 1);
    expect_flash(12, 8, 0);
    pulses(1);
    goto_cyc(t0 + 3);
    pulses(5);
    check("sat_pending", int'(pending), 3);
    check("sat_ovf_set", int'(ovf), 1);
    wait_idle(n);
    check("sat_ovf_sticky", int'(ovf), 1);
    check("sat_pending_drained", int'(pending), 0);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("sat_ovf_cleared", int'(ovf), 0);
    check("sat_sb_empty", exp_q.size(), 0);

    // Event coincides with OFF->ON while one is already queued.
    align();
    t0 = cyc;
    expect_flash(12, -1, 0);
    expect_flash(12, 8, 1);
    expect_flash(12, 8, 0);
    pulses(2);
    goto_cyc(t0 + 20);
    pulses(1);
    check("xfer_pending_hold", int'(pending), 1);
    check("xfer_led_on", int'(led_out), 1);
    wait_idle(n);
    check("xfer_sb_empty", exp_q.size(), 0);

    // Event coincides with the final OFF tick and nothing queued.
    align();
    t0 = cyc;
    expect_flash(12, -1, 0);
    expect_flash(12, 8, 0);
    pulses(1);
    goto_cyc(t0 + 20);
    pulses(1);
    check("direct_pending", int'(pending), 0);
    check("direct_led_on", int'(led_out), 1);
    wait_idle(n);
    check("direct_sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-flash discards the queue.
    align();
    pulses(3);
    check("rst_pending_before", int'(pending), 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_led", int'(led_out), 0);
    check("rst_async_pending", int'(pending), 0);
    check("rst_async_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("post_rst_dark", int'({led_out, busy, pending}), 0);
    end
    check("rst_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
